// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its program memory.
package fetch_unit_pkg;
    localparam int PROG_DEPTH = 16;
    localparam int PC_W       = 4;
    localparam int INSTR_W    = 8;

    // Instruction byte layout: [7:5] opcode, [4:0] immediate
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int IMM_MSB = 4;
    localparam int IMM_LSB = 0;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;
endpackage

// File: rtl/fetch_unit_prog_mem.sv
// 16x8 program store with auto-incrementing write pointer and full flag; async read.
// Writes are dropped once all 16 slots have been filled until the pointer is cleared.
module prog_mem
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o,
    output logic               full_o
);
    logic [INSTR_W-1:0] mem_q [PROG_DEPTH];
    logic [PC_W-1:0]    waddr_q;
    logic               full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            waddr_q <= '0;
            full_q  <= 1'b0;
        end else if (clr_i) begin
            waddr_q <= '0;
            full_q  <= 1'b0;
        end else if (wr_en_i && !full_q) begin
            mem_q[waddr_q] <= wdata_i;
            waddr_q        <= waddr_q + PC_W'(1);
            // Pointer wraps to 0 on the last slot; full blocks overwriting slot 0
            if (waddr_q == PC_W'(PROG_DEPTH - 1)) begin
                full_q <= 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];
    assign full_o  = full_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program-load mode fills prog_mem, run mode streams pc/ir with zero-bubble branches.
// Optional FETCH_STEP_EN adds a step input that gates RUN advancement (mode changes ignore step).
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_mode,
    input  logic               prog_valid,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               prog_ready,
    input  logic               bez,
    input  logic               ja,
    input  logic               zero,
`ifdef FETCH_STEP_EN
    input  logic               step,
`endif
    output logic [OPC_W-1:0]   opcode,
    output logic [IMM_W-1:0]   imm,
    output logic [PC_W-1:0]    pc,
    output logic               instr_valid
);
    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    next_pc, rd_addr;
    logic [INSTR_W-1:0] rdata;
    logic               taken, advance, full, mem_clr, mem_we;

`ifdef FETCH_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // imm[4] is dropped: branch targets cover only the 16-entry store
    assign taken   = (bez & zero) | ja;
    assign next_pc = taken ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
    assign rd_addr = (state_q == RUN) ? next_pc : '0;

    prog_mem u_mem (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (mem_clr),
        .wr_en_i (mem_we),
        .wdata_i (prog_data),
        .raddr_i (rd_addr),
        .rdata_o (rdata),
        .full_o  (full)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mem_clr = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (prog_mode) begin
                    state_d = LOAD;
                end else begin
                    state_d = RUN;
                    pc_d    = '0;
                    ir_d    = rdata;
                end
            end
            LOAD: begin
                if (prog_mode) begin
                    mem_we = prog_valid && !full;
                end else begin
                    state_d = RUN;
                    pc_d    = '0;
                    ir_d    = rdata;
                    mem_clr = 1'b1;
                end
            end
            RUN: begin
                if (prog_mode) begin
                    state_d = LOAD;
                    mem_clr = 1'b1;
                end else if (advance) begin
                    pc_d = next_pc;
                    ir_d = rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign prog_ready  = (state_q == LOAD) && !full;
    assign instr_valid = (state_q == RUN);
    assign opcode      = ir_q[OPC_MSB:OPC_LSB];
    assign imm         = ir_q[IMM_MSB:IMM_LSB];
    assign pc          = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, load/run sequencing, jumps, branches, full store, wrap.
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       reset, prog_mode, prog_valid, bez, ja, zero;
    logic [7:0] prog_data;
    logic       prog_ready, instr_valid;
    logic [2:0] opcode;
    logic [4:0] imm;
    logic [3:0] pc;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .prog_mode   (prog_mode),
        .prog_valid  (prog_valid),
        .prog_data   (prog_data),
        .prog_ready  (prog_ready),
        .bez         (bez),
        .ja          (ja),
        .zero        (zero),
`ifdef FETCH_STEP_EN
        .step        (1'b1),
`endif
        .opcode      (opcode),
        .imm         (imm),
        .pc          (pc),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_run(input string tag, input logic [3:0] exp_pc, input logic [7:0] exp_ir);
        check({tag, "_valid"}, {7'd0, instr_valid}, 8'h01);
        check({tag, "_pc"}, {4'd0, pc}, {4'd0, exp_pc});
        check({tag, "_ir"}, {opcode, imm}, exp_ir);
    endtask

    logic [7:0] first3 [3];
    logic [7:0] prog   [16];

    initial begin
        reset = 1'b1; prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        bez = 1'b0; ja = 1'b0; zero = 1'b0;
        first3[0] = 8'h21; first3[1] = 8'h22; first3[2] = 8'h23;
        for (int i = 0; i < 16; i++) prog[i] = 8'h40 | 8'(i);
        prog[0] = 8'h21; prog[2] = 8'hC9; prog[4] = 8'h9A;

        tick(); tick();
        check("rst_ready", {7'd0, prog_ready}, 8'h00);
        check("rst_valid", {7'd0, instr_valid}, 8'h00);
        check("rst_ir", {opcode, imm}, 8'h00);
        check("rst_pc", {4'd0, pc}, 8'h00);

        reset = 1'b0;
        check("post_rst_valid", {7'd0, instr_valid}, 8'h00);
        check("post_rst_ready", {7'd0, prog_ready}, 8'h00);
        tick();
        check_run("boot", 4'd0, 8'h00);

        prog_mode = 1'b1;
        tick();
        check("load_valid", {7'd0, instr_valid}, 8'h00);
        check("load_ready", {7'd0, prog_ready}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1'b1; prog_data = first3[i];
            tick();
        end
        prog_valid = 1'b0; prog_mode = 1'b0;
        tick(); check_run("seq0", 4'd0, 8'h21);
        tick(); check_run("seq1", 4'd1, 8'h22);
        tick(); check_run("seq2", 4'd2, 8'h23);

        // Fill all 16 slots, then a 17th byte that must be refused
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            prog_valid = 1'b1;
            prog_data  = (i < 16) ? prog[i] : 8'hEE;
            check("fill_ready", {7'd0, prog_ready}, (i < 16) ? 8'h01 : 8'h00);
            tick();
        end
        prog_valid = 1'b0;
        check("full_ready", {7'd0, prog_ready}, 8'h00);
        prog_mode = 1'b0;
        tick(); check_run("mem0_kept", 4'd0, 8'h21);
        tick(); check_run("run1", 4'd1, 8'h41);
        tick(); check_run("ja_in_ir", 4'd2, 8'hC9);
        ja = 1'b1;
        tick();
        ja = 1'b0;
        check_run("ja_target", 4'd9, 8'h49);
        repeat (6) tick();
        check_run("pc15", 4'd15, 8'h4F);
        tick(); check_run("wrap", 4'd0, 8'h21);

        repeat (4) tick();
        check_run("bez_in_ir", 4'd4, 8'h9A);
        bez = 1'b1; zero = 1'b0;
        tick();
        bez = 1'b0;
        check_run("bez_nt", 4'd5, 8'h45);
        repeat (15) tick();
        check_run("bez_again", 4'd4, 8'h9A);
        bez = 1'b1; zero = 1'b1;
        tick();
        bez = 1'b0; zero = 1'b0;
        check_run("bez_t", 4'd10, 8'h4A);

        // Reset in the middle of a load wipes the store
        prog_mode = 1'b1;
        tick();
        prog_valid = 1'b1; prog_data = 8'h77;
        tick();
        check("midload_ready", {7'd0, prog_ready}, 8'h01);
        reset = 1'b1;
        tick();
        check("midrst_ready", {7'd0, prog_ready}, 8'h00);
        check("midrst_valid", {7'd0, instr_valid}, 8'h00);
        check("midrst_pc", {4'd0, pc}, 8'h00);
        check("midrst_ir", {opcode, imm}, 8'h00);
        reset = 1'b0; prog_valid = 1'b0; prog_mode = 1'b0;
        tick();
        check_run("clr0", 4'd0, 8'h00);
        for (int p = 1; p < 16; p++) begin
            tick();
            check_run("clr", 4'(p), 8'h00);
        end
        tick();
        check_run("clr_wrap", 4'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port prog_mode, input, 1: high selects program-load mode, low selects run mode.
REQ-004 SHALL have port prog_valid, input, 1: prog_data carries an instruction byte to store.
REQ-005 SHALL have port prog_data, input, 8: instruction byte; [7:5] opcode, [4:0] immediate.
REQ-006 SHALL have port prog_ready, output, 1: a store completes on a cycle where prog_valid and prog_ready are both high.
REQ-007 SHALL have port bez, input, 1: branch-if-zero control from the decoder, for the instruction in ir.
REQ-008 SHALL have port ja, input, 1: unconditional jump control from the decoder, for the instruction in ir.
REQ-009 SHALL have port zero, input, 1: datapath x8==0 flag.
REQ-010 SHALL have port opcode, output, 3: ir[7:5], drives the decoder.
REQ-011 SHALL have port imm, output, 5: ir[4:0].
REQ-012 SHALL have port pc, output, 4: address of the instruction held in ir.
REQ-013 SHALL have port instr_valid, output, 1: ir holds a live instruction (state RUN).

Function
REQ-014 SHALL hold a 16x8 program memory, a 4-bit write pointer waddr, pc, an 8-bit ir, and a state register with states IDLE, LOAD, RUN.
REQ-015 SHALL, in IDLE, go to LOAD if prog_mode=1; otherwise go to RUN, loading pc<=0 and ir<=mem[0].
REQ-016 SHALL, in LOAD, assert prog_ready=1 while the full flag is 0.
REQ-017 SHALL, on each LOAD handshake, write mem[waddr]<=prog_data and increment waddr.
REQ-018 SHALL set full on the 16th handshake (waddr wraps 15->0); while full, prog_ready=0 and no writes occur.
REQ-019 SHALL, in LOAD with prog_mode=0, go to RUN with pc<=0, ir<=mem[0], and clear full and waddr; a prog_valid on that cycle is ignored.
REQ-020 SHALL define, in RUN: taken=(bez&zero)|ja, target=imm[3:0], next_pc=taken?target:pc+1 (4-bit, 15 wraps to 0).
REQ-021 SHALL, each RUN cycle: pc<=next_pc, ir<=mem[next_pc]; a redirect takes effect one cycle after the branch is in ir, with no bubble.
REQ-022 SHALL treat bez with imm[4]=1 by ignoring imm[4] (target is 4 bits).
REQ-023 SHALL, in RUN with prog_mode=1, go to LOAD next cycle with waddr<=0, full<=0, instr_valid=0; memory is preserved.
REQ-024 SHALL drive opcode/imm directly from ir and instr_valid=1 only in RUN; prog_ready=0 outside LOAD.

Reset
REQ-025 SHALL, on reset, clear state to IDLE, pc, ir, waddr, full, and all 16 memory bytes to 0.
REQ-026 SHALL drive prog_ready=0, instr_valid=0, opcode=0, imm=0, pc=0 during and immediately after reset.
REQ-027 SHALL let reset override all other inputs, including mid-load and mid-run.

Configuration
REQ-028 SHALL support macro FETCH_STEP_EN; when defined, add port step (input, 1) and advance RUN only on cycles where step=1, holding pc/ir otherwise.
REQ-029 SHALL, when FETCH_STEP_EN is defined, let prog_mode transitions take effect regardless of step.
REQ-030 SHALL, without FETCH_STEP_EN, have no step port and advance RUN every cycle.

Structure
REQ-031 SHALL place in the shared package: state enum (IDLE/LOAD/RUN), PROG_DEPTH=16, PC_W=4, INSTR_W=8, and opcode field slice constants.
REQ-032 SHALL implement the 16x8 memory and write pointer as sub-module prog_mem; all else stays in fetch_unit.

Verification
REQ-033 SHALL cover: reset, prog_mode=0 -> after 2 cycles state RUN, pc=0, ir=0x00, instr_valid=1.
REQ-034 SHALL cover: load 0x21,0x22,0x23 then prog_mode=0 -> opcode=1 on pc=0,1,2 on consecutive cycles.
REQ-035 SHALL cover: mem[2]=0xC9 (ja 9), ja=1 with pc=2 -> next cycle pc=9, ir=mem[9].
REQ-036 SHALL cover: bez at pc=4 targeting 0xA with zero=0 -> pc=5; same with zero=1 -> pc=0xA.
REQ-037 SHALL cover: 17 back-to-back prog_valid -> prog_ready drops after the 16th; mem[0] keeps the first byte.
REQ-038 SHALL cover: at pc=15 with no branch -> pc=0; reset asserted mid-LOAD -> IDLE and all memory reads 0.
